// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/WB command sequencer around an external 8-bit ALU and a small register file.
// Optional feature macro ALU_SEQ_CARRY_CHAIN_EN: drives AluCin from FlagC during EXEC for multi-byte chains.
module alu_sequencer #(
    parameter int REG_ADDR_W = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic [2:0]            CmdOp,
    input  logic [REG_ADDR_W-1:0] CmdSrcA,
    input  logic [REG_ADDR_W-1:0] CmdSrcB,
    input  logic [REG_ADDR_W-1:0] CmdDst,
    input  logic                  LoadEn,
    input  logic [REG_ADDR_W-1:0] LoadAddr,
    input  logic [7:0]            LoadData,
    input  logic [REG_ADDR_W-1:0] RdAddr,
    output logic [7:0]            RdData,
    output logic [7:0]            AluA,
    output logic [7:0]            AluB,
    output logic                  AluCin,
    output logic [2:0]            AluOp,
    input  logic [7:0]            AluOut,
    input  logic                  AluCout,
    input  logic                  AluZero,
    input  logic                  AluSign,
    output logic                  FlagC,
    output logic                  FlagZ,
    output logic                  FlagS,
    output logic                  Done,
    output logic                  ErrOp
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b111;
    localparam logic [2:0] OP_ILL_A = 3'b101;
    localparam logic [2:0] OP_ILL_B = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] rf [NUM_REGS];

    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] src_a_q;
    logic [REG_ADDR_W-1:0] src_b_q;
    logic [REG_ADDR_W-1:0] dst_q;

    logic [7:0] res_q;
    logic       cout_q;
    logic       zero_q;
    logic       sign_q;

    logic flag_c;
    logic flag_z;
    logic flag_s;
    logic done_q;
    logic err_q;

    logic accept;
    logic op_legal;
    logic op_arith;

    assign CmdReady = (state == IDLE) && !Reset;
    assign accept   = CmdValid && CmdReady;
    assign op_legal = (op_q != OP_ILL_A) && (op_q != OP_ILL_B);
    assign op_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values; blocking here would race.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults assigned first so no path leaves an output unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The ALU is driven only while a command is executing; it sees zeros otherwise.
    always_comb begin
        AluA   = 8'h00;
        AluB   = 8'h00;
        AluOp  = 3'b000;
        AluCin = 1'b0;
        if (state == EXEC) begin
            AluA  = rf[src_a_q];
            AluB  = rf[src_b_q];
            AluOp = op_q;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            AluCin = flag_c;
`else
            AluCin = 1'b0;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q    <= 3'b000;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
        end else if (accept) begin
            op_q    <= CmdOp;
            src_a_q <= CmdSrcA;
            src_b_q <= CmdSrcB;
            dst_q   <= CmdDst;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_q  <= 8'h00;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            sign_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q  <= AluOut;
            cout_q <= AluCout;
            zero_q <= AluZero;
            sign_q <= AluSign;
        end
    end

    // NOTE: the register file is architecturally visible and must read 0x00 after reset, so it is reset per entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= 8'h00;
            end
        end else if ((state == IDLE) && LoadEn) begin
            rf[LoadAddr] <= LoadData;
        end else if ((state == WB) && op_legal) begin
            rf[dst_q] <= res_q;
        end
    end

    // Logic ops clear carry; ALU carry output is meaningless for them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
        end else if ((state == WB) && op_legal) begin
            flag_c <= op_arith ? cout_q : 1'b0;
            flag_z <= zero_q;
            flag_s <= sign_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == WB) && op_legal;
            err_q  <= (state == WB) && !op_legal;
        end
    end

    assign RdData = rf[RdAddr];
    assign FlagC  = flag_c;
    assign FlagZ  = flag_z;
    assign FlagS  = flag_s;
    assign Done   = done_q;
    assign ErrOp  = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer with a behavioural 8-bit ALU on the ALU port.
// Expectations that depend on ALU_SEQ_CARRY_CHAIN_EN follow the same macro.
module tb_alu_sequencer;

    localparam int REG_ADDR_W = 2;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    localparam logic [7:0] EXP_BORROW = 8'hFD;
    localparam logic [7:0] EXP_CHAIN  = 8'h03;
`else
    localparam logic [7:0] EXP_BORROW = 8'hFE;
    localparam logic [7:0] EXP_CHAIN  = 8'h02;
`endif

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  CmdValid;
    logic                  CmdReady;
    logic [2:0]            CmdOp;
    logic [REG_ADDR_W-1:0] CmdSrcA;
    logic [REG_ADDR_W-1:0] CmdSrcB;
    logic [REG_ADDR_W-1:0] CmdDst;
    logic                  LoadEn;
    logic [REG_ADDR_W-1:0] LoadAddr;
    logic [7:0]            LoadData;
    logic [REG_ADDR_W-1:0] RdAddr;
    logic [7:0]            RdData;
    logic [7:0]            AluA;
    logic [7:0]            AluB;
    logic                  AluCin;
    logic [2:0]            AluOp;
    logic [7:0]            AluOut;
    logic                  AluCout;
    logic                  AluZero;
    logic                  AluSign;
    logic                  FlagC;
    logic                  FlagZ;
    logic                  FlagS;
    logic                  Done;
    logic                  ErrOp;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    // External ALU. Logic ops drive carry high so a leak into FlagC is visible.
    logic [8:0] sum9;
    always_comb begin
        sum9    = 9'h000;
        AluOut  = 8'h00;
        AluCout = 1'b0;
        case (AluOp)
            3'b011: begin
                sum9    = {1'b0, AluA} + {1'b0, AluB} + {8'h00, AluCin};
                AluOut  = sum9[7:0];
                AluCout = sum9[8];
            end
            3'b111: begin
                sum9    = {1'b0, AluA} + {1'b0, ~AluB} + {8'h00, ~AluCin};
                AluOut  = sum9[7:0];
                AluCout = sum9[8];
            end
            3'b000: begin AluOut = ~AluA;       AluCout = 1'b1; end
            3'b001: begin AluOut = AluA & AluB; AluCout = 1'b1; end
            3'b010: begin AluOut = AluA | AluB; AluCout = 1'b1; end
            3'b100: begin AluOut = AluA ^ AluB; AluCout = 1'b1; end
            default: begin AluOut = 8'hAA;      AluCout = 1'b1; end
        endcase
        AluZero = (AluOut == 8'h00);
        AluSign = AluOut[7];
    end

    alu_sequencer #(.REG_ADDR_W(REG_ADDR_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdOp    (CmdOp),
        .CmdSrcA  (CmdSrcA),
        .CmdSrcB  (CmdSrcB),
        .CmdDst   (CmdDst),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .AluA     (AluA),
        .AluB     (AluB),
        .AluCin   (AluCin),
        .AluOp    (AluOp),
        .AluOut   (AluOut),
        .AluCout  (AluCout),
        .AluZero  (AluZero),
        .AluSign  (AluSign),
        .FlagC    (FlagC),
        .FlagZ    (FlagZ),
        .FlagS    (FlagS),
        .Done     (Done),
        .ErrOp    (ErrOp)
    );

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        LoadEn   = 1'b1;
        LoadAddr = addr;
        LoadData = data;
        @(posedge Clk); #1;
        LoadEn   = 1'b0;
    endtask

    // Issues one command from an IDLE cycle and follows it to the cycle after its Done/ErrOp pulse.
    // ld_mode: 0 none, 1 load in the accept cycle, 2 load during EXEC.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [1:0] dst, input logic [7:0] exp_a, input logic [7:0] exp_b,
                           input logic exp_err, input int ld_mode, input logic [1:0] ld_addr,
                           input logic [7:0] ld_data, input string tag);
        int cycles;
        checks++;
        if (CmdReady !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", tag, CmdReady);
        end
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdSrcA  = sa;
        CmdSrcB  = sb;
        CmdDst   = dst;
        if (ld_mode == 1) begin
            LoadEn = 1'b1; LoadAddr = ld_addr; LoadData = ld_data;
        end
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        LoadEn   = 1'b0;
        if (ld_mode == 2) begin
            LoadEn = 1'b1; LoadAddr = ld_addr; LoadData = ld_data;
        end
        checks++;
        if ({AluA, AluB, AluOp} !== {exp_a, exp_b, op}) begin
            errors++;
            $display("FAIL %s exec_operands: got a=%h b=%h op=%b expected a=%h b=%h op=%b",
                     tag, AluA, AluB, AluOp, exp_a, exp_b, op);
        end
        @(posedge Clk); #1;
        LoadEn = 1'b0;
        checks++;
        if ({AluA, AluB, AluOp, AluCin, Done, ErrOp} !== 21'd0) begin
            errors++;
            $display("FAIL %s wb_idle_alu: got a=%h b=%h op=%b cin=%b done=%b err=%b expected all 0",
                     tag, AluA, AluB, AluOp, AluCin, Done, ErrOp);
        end
        cycles = 2;
        while (Done !== 1'b1 && ErrOp !== 1'b1 && cycles < 10) begin
            @(posedge Clk); #1;
            cycles++;
        end
        checks++;
        if (cycles != 3) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected 3", tag, cycles);
        end
        checks++;
        if ({Done, ErrOp, CmdReady} !== {~exp_err, exp_err, 1'b1}) begin
            errors++;
            $display("FAIL %s retire: got done=%b err=%b ready=%b expected done=%b err=%b ready=1",
                     tag, Done, ErrOp, CmdReady, ~exp_err, exp_err);
        end
        @(posedge Clk); #1;
        checks++;
        if ({Done, ErrOp} !== 2'b00) begin
            errors++;
            $display("FAIL %s pulse_width: got done=%b err=%b expected 00", tag, Done, ErrOp);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({CmdReady, Done, ErrOp, FlagC, FlagZ, FlagS} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b done=%b err=%b czs=%b%b%b expected all 0",
                     CmdReady, Done, ErrOp, FlagC, FlagZ, FlagS);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({CmdReady, AluA, AluB, AluOp, AluCin} !== {1'b1, 20'd0}) begin
            errors++;
            $display("FAIL reset_release: got ready=%b a=%h b=%h op=%b cin=%b expected ready=1 rest 0",
                     CmdReady, AluA, AluB, AluOp, AluCin);
        end
        for (int i = 0; i < 4; i++) begin
            RdAddr = 2'(i);
            #1;
            checks++;
            if (RdData !== 8'h00) begin
                errors++;
                $display("FAIL reset_rf%0d: got %h expected 00", i, RdData);
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_add();
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        run_cmd(3'b011, 2'd0, 2'd1, 2'd2, 8'h05, 8'h03, 1'b0, 0, 2'd0, 8'h00, "add");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h08, 3'b000}) begin
            errors++;
            $display("FAIL add_result: got %h czs=%b%b%b expected 08 czs=000", RdData, FlagC, FlagZ, FlagS);
        end
    endtask

    task automatic test_sub();
        load(2'd0, 8'h03);
        load(2'd1, 8'h03);
        run_cmd(3'b111, 2'd0, 2'd1, 2'd3, 8'h03, 8'h03, 1'b0, 0, 2'd0, 8'h00, "sub_equal");
        RdAddr = 2'd3; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h00, 3'b110}) begin
            errors++;
            $display("FAIL sub_equal_result: got %h czs=%b%b%b expected 00 czs=110", RdData, FlagC, FlagZ, FlagS);
        end
        load(2'd1, 8'h05);
        run_cmd(3'b111, 2'd0, 2'd1, 2'd2, 8'h03, 8'h05, 1'b0, 0, 2'd0, 8'h00, "sub_borrow");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {EXP_BORROW, 3'b001}) begin
            errors++;
            $display("FAIL sub_borrow_result: got %h czs=%b%b%b expected %h czs=001",
                     RdData, FlagC, FlagZ, FlagS, EXP_BORROW);
        end
    endtask

    task automatic test_carry();
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        run_cmd(3'b011, 2'd0, 2'd1, 2'd2, 8'hFF, 8'h01, 1'b0, 0, 2'd0, 8'h00, "add_wrap");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h00, 3'b110}) begin
            errors++;
            $display("FAIL add_wrap_result: got %h czs=%b%b%b expected 00 czs=110", RdData, FlagC, FlagZ, FlagS);
        end
        run_cmd(3'b011, 2'd1, 2'd1, 2'd3, 8'h01, 8'h01, 1'b0, 0, 2'd0, 8'h00, "add_chain");
        RdAddr = 2'd3; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {EXP_CHAIN, 3'b000}) begin
            errors++;
            $display("FAIL add_chain_result: got %h czs=%b%b%b expected %h czs=000",
                     RdData, FlagC, FlagZ, FlagS, EXP_CHAIN);
        end
    endtask

    task automatic test_logic();
        run_cmd(3'b011, 2'd0, 2'd1, 2'd2, 8'hFF, 8'h01, 1'b0, 0, 2'd0, 8'h00, "logic_setc");
        load(2'd0, 8'hF0);
        load(2'd1, 8'h3C);
        run_cmd(3'b001, 2'd0, 2'd1, 2'd2, 8'hF0, 8'h3C, 1'b0, 0, 2'd0, 8'h00, "and");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h30, 3'b000}) begin
            errors++;
            $display("FAIL and_result: got %h czs=%b%b%b expected 30 czs=000", RdData, FlagC, FlagZ, FlagS);
        end
        run_cmd(3'b010, 2'd0, 2'd1, 2'd3, 8'hF0, 8'h3C, 1'b0, 0, 2'd0, 8'h00, "or");
        RdAddr = 2'd3; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'hFC, 3'b001}) begin
            errors++;
            $display("FAIL or_result: got %h czs=%b%b%b expected fc czs=001", RdData, FlagC, FlagZ, FlagS);
        end
        run_cmd(3'b100, 2'd0, 2'd1, 2'd2, 8'hF0, 8'h3C, 1'b0, 0, 2'd0, 8'h00, "xor");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'hCC, 3'b001}) begin
            errors++;
            $display("FAIL xor_result: got %h czs=%b%b%b expected cc czs=001", RdData, FlagC, FlagZ, FlagS);
        end
        run_cmd(3'b000, 2'd0, 2'd1, 2'd3, 8'hF0, 8'h3C, 1'b0, 0, 2'd0, 8'h00, "not");
        RdAddr = 2'd3; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h0F, 3'b000}) begin
            errors++;
            $display("FAIL not_result: got %h czs=%b%b%b expected 0f czs=000", RdData, FlagC, FlagZ, FlagS);
        end
        load(2'd1, 8'h0F);
        run_cmd(3'b001, 2'd0, 2'd1, 2'd2, 8'hF0, 8'h0F, 1'b0, 0, 2'd0, 8'h00, "and_zero");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h00, 3'b010}) begin
            errors++;
            $display("FAIL and_zero_result: got %h czs=%b%b%b expected 00 czs=010", RdData, FlagC, FlagZ, FlagS);
        end
    endtask

    task automatic test_illegal();
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        load(2'd3, 8'h5A);
        run_cmd(3'b011, 2'd0, 2'd1, 2'd2, 8'hFF, 8'h01, 1'b0, 0, 2'd0, 8'h00, "ill_setup");
        run_cmd(3'b101, 2'd0, 2'd1, 2'd2, 8'hFF, 8'h01, 1'b1, 0, 2'd0, 8'h00, "ill_101");
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h00, 3'b110}) begin
            errors++;
            $display("FAIL ill_101_state: got %h czs=%b%b%b expected 00 czs=110", RdData, FlagC, FlagZ, FlagS);
        end
        run_cmd(3'b110, 2'd0, 2'd1, 2'd3, 8'hFF, 8'h01, 1'b1, 0, 2'd0, 8'h00, "ill_110");
        RdAddr = 2'd3; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h5A, 3'b110}) begin
            errors++;
            $display("FAIL ill_110_state: got %h czs=%b%b%b expected 5a czs=110", RdData, FlagC, FlagZ, FlagS);
        end
    endtask

    task automatic test_reset_in_wb();
        load(2'd0, 8'h01);
        load(2'd1, 8'h02);
        CmdValid = 1'b1; CmdOp = 3'b011; CmdSrcA = 2'd0; CmdSrcB = 2'd1; CmdDst = 2'd3;
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if ({Done, ErrOp, CmdReady} !== 3'b000) begin
            errors++;
            $display("FAIL wb_reset_held: got done=%b err=%b ready=%b expected 000", Done, ErrOp, CmdReady);
        end
        Reset = 1'b0;
        RdAddr = 2'd3; #1;
        checks++;
        if ({CmdReady, RdData, FlagC, FlagZ, FlagS} !== {1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL wb_reset_release: got ready=%b r3=%h czs=%b%b%b expected ready=1 r3=00 czs=000",
                     CmdReady, RdData, FlagC, FlagZ, FlagS);
        end
        @(posedge Clk); #1;
        checks++;
        if ({Done, ErrOp, CmdReady} !== 3'b001) begin
            errors++;
            $display("FAIL wb_reset_after: got done=%b err=%b ready=%b expected 001", Done, ErrOp, CmdReady);
        end
    endtask

    task automatic test_load_rules();
        load(2'd0, 8'h10);
        load(2'd1, 8'h20);
        run_cmd(3'b011, 2'd0, 2'd1, 2'd2, 8'h10, 8'h20, 1'b0, 2, 2'd0, 8'h77, "load_in_exec");
        RdAddr = 2'd0; #1;
        checks++;
        if (RdData !== 8'h10) begin
            errors++;
            $display("FAIL load_in_exec_r0: got %h expected 10", RdData);
        end
        RdAddr = 2'd2; #1;
        checks++;
        if (RdData !== 8'h30) begin
            errors++;
            $display("FAIL load_in_exec_r2: got %h expected 30", RdData);
        end
        run_cmd(3'b011, 2'd0, 2'd1, 2'd3, 8'h40, 8'h20, 1'b0, 1, 2'd0, 8'h40, "load_with_accept");
        RdAddr = 2'd3; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h60, 3'b000}) begin
            errors++;
            $display("FAIL load_with_accept_r3: got %h czs=%b%b%b expected 60 czs=000", RdData, FlagC, FlagZ, FlagS);
        end
    endtask

    task automatic test_back_to_back();
        load(2'd0, 8'h07);
        run_cmd(3'b011, 2'd0, 2'd0, 2'd0, 8'h07, 8'h07, 1'b0, 0, 2'd0, 8'h00, "dst_is_src");
        RdAddr = 2'd0; #1;
        checks++;
        if (RdData !== 8'h0E) begin
            errors++;
            $display("FAIL dst_is_src_r0: got %h expected 0e", RdData);
        end
        CmdValid = 1'b1; CmdOp = 3'b100; CmdSrcA = 2'd0; CmdSrcB = 2'd0; CmdDst = 2'd1;
        @(posedge Clk); #1;
        CmdOp = 3'b011; CmdDst = 2'd2;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++;
        if ({Done, CmdReady} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_first_done: got done=%b ready=%b expected 11", Done, CmdReady);
        end
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        checks++;
        if ({Done, AluOp, AluA} !== {1'b0, 3'b011, 8'h0E}) begin
            errors++;
            $display("FAIL b2b_second_exec: got done=%b op=%b a=%h expected done=0 op=011 a=0e", Done, AluOp, AluA);
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        RdAddr = 2'd1; #1;
        checks++;
        if ({Done, RdData} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL b2b_second_done_r1: got done=%b r1=%h expected done=1 r1=00", Done, RdData);
        end
        RdAddr = 2'd2; #1;
        checks++;
        if ({RdData, FlagC, FlagZ, FlagS} !== {8'h1C, 3'b000}) begin
            errors++;
            $display("FAIL b2b_r2: got %h czs=%b%b%b expected 1c czs=000", RdData, FlagC, FlagZ, FlagS);
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        CmdValid = 1'b0;
        CmdOp    = 3'b000;
        CmdSrcA  = '0;
        CmdSrcB  = '0;
        CmdDst   = '0;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = 8'h00;
        RdAddr   = '0;
        test_reset();
        test_add();
        test_sub();
        test_carry();
        test_logic();
        test_illegal();
        test_reset_in_wb();
        test_load_rules();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
